multi_indicator: RTL and testbench

MULTI_INDICATOR -- requirements
Module: multi_indicator

---
 rtl/multi_indicator.sv | 223 ++++++++++++++++++++++
 tb/tb_multi_indicator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_indicator.sv
// multi_indicator
//   Battery charger indicator for CH independent channels. A debounced user
//   button opens a "show" window; each channel classifies its charger STAT
//   pin as charging, not charging or fault (STAT toggling), and drives a
//   red/green LED pair from the classification, supply presence and battery
//   level. Fault is shown as a red blink shared by all channels.
//
// Ports
//   clk     in   1   system clock, rising edge
//   rst     in   1   asynchronous active-high reset
//   button  in   1   user button (async), 1 = pressed
//   usb     in   CH  supply present per channel (async)
//   level   in   CH  battery full per channel (async)
//   stat    in   CH  charger STAT pin per channel (async)
//   red     out  CH  red LED drive, registered
//   green   out  CH  green LED drive, registered
//   fault   out  CH  1 while the channel classifier is in FAULT, registered
//
// Classifier states
//   state  | meaning
//   NOTCHG | STAT steady high: not charging (or charge complete)
//   CHG    | STAT steady low: charging
//   FAULT  | STAT edges closer together than FLT_WIN cycles
module multi_indicator #(
    parameter int CH        = 2,
    parameter int DEB_CYC   = 8,
    parameter int BLINK_DIV = 16,
    parameter int SHOW_CYC  = 64,
    parameter int FLT_WIN   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          button,
    input  logic [CH-1:0] usb,
    input  logic [CH-1:0] level,
    input  logic [CH-1:0] stat,
    output logic [CH-1:0] red,
    output logic [CH-1:0] green,
    output logic [CH-1:0] fault
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int SW = $clog2(SHOW_CYC + 1);
    localparam int GW = $clog2(FLT_WIN + 1);

    localparam logic [DW-1:0] DEB_RELOAD   = DW'(DEB_CYC - 1);
    localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SHOW_LOAD    = SW'(SHOW_CYC);
    localparam logic [GW-1:0] GAP_MAX      = GW'(FLT_WIN);

    typedef enum logic [1:0] {
        NOTCHG = 2'd0,
        CHG    = 2'd1,
        FAULT  = 2'd2
    } cls_t;

    // ------------------------------------------------------------------
    // Two-flop synchronisers
    // ------------------------------------------------------------------
    logic          button_m, button_s;
    logic [CH-1:0] usb_m, usb_s;
    logic [CH-1:0] level_m, level_s;
    logic [CH-1:0] stat_m, stat_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            button_m <= 1'b0;
            button_s <= 1'b0;
            usb_m    <= '0;
            usb_s    <= '0;
            level_m  <= '0;
            level_s  <= '0;
            stat_m   <= '0;
            stat_s   <= '0;
        end else begin
            button_m <= button;
            button_s <= button_m;
            usb_m    <= usb;
            usb_s    <= usb_m;
            level_m  <= level;
            level_s  <= level_m;
            stat_m   <= stat;
            stat_s   <= stat_m;
        end
    end

    // ------------------------------------------------------------------
    // Button debounce and show window
    // ------------------------------------------------------------------
    logic          deb;
    logic [DW-1:0] deb_cnt;
    logic [SW-1:0] tail_cnt;
    logic          show;

    // deb_cnt counts down the remaining cycles the synchronised level must
    // stay different before it is accepted; tail_cnt holds the window open
    // after the debounced button falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb      <= 1'b0;
            deb_cnt  <= DEB_RELOAD;
            tail_cnt <= '0;
        end else begin
            if (button_s != deb) begin
                if (deb_cnt == '0) begin
                    deb     <= button_s;
                    deb_cnt <= DEB_RELOAD;
                end else begin
                    deb_cnt <= deb_cnt - 1'b1;
                end
            end else begin
                deb_cnt <= DEB_RELOAD;
            end

            if (deb && !button_s && deb_cnt == '0) begin
                tail_cnt <= SHOW_LOAD;
            end else if (deb) begin
                tail_cnt <= '0;
            end else if (tail_cnt != '0) begin
                tail_cnt <= tail_cnt - 1'b1;
            end
        end
    end

    assign show = deb | (tail_cnt != '0);

    // ------------------------------------------------------------------
    // Shared blink generator
    // ------------------------------------------------------------------
    logic          blink;
    logic [BW-1:0] blink_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink     <= 1'b0;
            blink_cnt <= BLINK_RELOAD;
        end else if (blink_cnt == '0) begin
            blink     <= ~blink;
            blink_cnt <= BLINK_RELOAD;
        end else begin
            blink_cnt <= blink_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel classifier and LED mapping
    // ------------------------------------------------------------------
    for (genvar g = 0; g < CH; g++) begin : g_ch
        cls_t          cls_q;
        logic [GW-1:0] gap_q;
        logic          stat_d;
        logic          stat_edge;
        logic          red_q;
        logic          green_q;
        logic          fault_q;

        assign stat_edge = stat_s[g] ^ stat_d;

        // Gap counter resets to its saturated value so the first edge after
        // reset is treated as an isolated transition, never as a fault.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cls_q  <= NOTCHG;
                gap_q  <= GAP_MAX;
                stat_d <= 1'b0;
            end else begin
                stat_d <= stat_s[g];
                if (stat_edge) begin
                    gap_q <= '0;
                    if (gap_q < GAP_MAX) begin
                        cls_q <= FAULT;
                    end else begin
                        cls_q <= stat_s[g] ? NOTCHG : CHG;
                    end
                end else begin
                    if (gap_q != GAP_MAX) begin
                        gap_q <= gap_q + 1'b1;
                    end
                    if (cls_q == FAULT && gap_q == GAP_MAX) begin
                        cls_q <= stat_s[g] ? NOTCHG : CHG;
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                red_q   <= 1'b0;
                green_q <= 1'b0;
                fault_q <= 1'b0;
            end else begin
                fault_q <= (cls_q == FAULT);
                if (!usb_s[g]) begin
                    // Unplugged: only the battery level matters, and only
                    // while the button window is open.
                    red_q   <= show & ~level_s[g];
                    green_q <= show & level_s[g];
                end else begin
                    case (cls_q)
                        FAULT: begin
                            red_q   <= blink;
                            green_q <= 1'b0;
                        end
                        CHG: begin
                            red_q   <= 1'b1;
                            green_q <= 1'b1;
                        end
                        default: begin
                            red_q   <= 1'b0;
                            green_q <= 1'b1;
                        end
                    endcase
                end
            end
        end

        assign red[g]   = red_q;
        assign green[g] = green_q;
        assign fault[g] = fault_q;
    end

endmodule

// File: tb/tb_multi_indicator.sv
// Self-checking bench for multi_indicator: directed scenarios plus random
// traffic, compared every cycle against an event/time based reference model.
module tb_multi_indicator;

    localparam int CH  = 2;
    localparam int DEB = 8;
    localparam int BD  = 16;
    localparam int SC  = 64;
    localparam int FW  = 32;
    localparam int OFF = 4;
    localparam int HN  = 4096;

    localparam int M_NOTCHG = 0;
    localparam int M_CHG    = 1;
    localparam int M_FAULT  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          button = 1'b0;
    logic [CH-1:0] usb = '0;
    logic [CH-1:0] level = '0;
    logic [CH-1:0] stat = '0;
    logic [CH-1:0] red, green, fault;

    always #5 clk = ~clk;

    multi_indicator #(
        .CH(CH), .DEB_CYC(DEB), .BLINK_DIV(BD), .SHOW_CYC(SC), .FLT_WIN(FW)
    ) dut (
        .clk(clk), .rst(rst), .button(button), .usb(usb), .level(level),
        .stat(stat), .red(red), .green(green), .fault(fault)
    );

    int n_checks = 0;
    int n_err    = 0;
    int n        = 0;

    // input history, sample of edge n stored at index n+OFF
    logic          h_btn  [HN];
    logic [CH-1:0] h_usb  [HN];
    logic [CH-1:0] h_lvl  [HN];
    logic [CH-1:0] h_stat [HN];

    int            m_st [CH];
    int            last_edge [CH];
    int            last_fall;
    int            run;
    logic          deb_m;
    logic          show_m;
    logic [CH-1:0] m_red, m_green, m_fault;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, n, got, exp);
        end
    endtask

    task automatic m_reset();
        n = 0;
        for (int i = 0; i < HN; i++) begin
            h_btn[i]  = 1'b0;
            h_usb[i]  = '0;
            h_lvl[i]  = '0;
            h_stat[i] = '0;
        end
        deb_m     = 1'b0;
        run       = 0;
        last_fall = -100000;
        show_m    = 1'b0;
        for (int c = 0; c < CH; c++) begin
            m_st[c]      = M_NOTCHG;
            last_edge[c] = -100000;
        end
        m_red   = '0;
        m_green = '0;
        m_fault = '0;
    endtask

    // Advance the model across edge n. Logic at edge n sees the synchronised
    // inputs sampled two edges earlier.
    task automatic m_edge();
        int   i2, i3, gap;
        logic bprev, sb, now_s, was_s;
        i2 = n - 2 + OFF;
        i3 = n - 3 + OFF;
        bprev = (((n - 1) / BD) % 2) == 1;

        for (int c = 0; c < CH; c++) begin
            if (!h_usb[i2][c]) begin
                m_red[c]   = show_m && !h_lvl[i2][c];
                m_green[c] = show_m && h_lvl[i2][c];
            end else if (m_st[c] == M_FAULT) begin
                m_red[c]   = bprev;
                m_green[c] = 1'b0;
            end else if (m_st[c] == M_CHG) begin
                m_red[c]   = 1'b1;
                m_green[c] = 1'b1;
            end else begin
                m_red[c]   = 1'b0;
                m_green[c] = 1'b1;
            end
            m_fault[c] = (m_st[c] == M_FAULT);
        end

        sb = h_btn[i2];
        if (sb != deb_m) begin
            run++;
            if (run == DEB) begin
                deb_m = sb;
                run   = 0;
                if (!sb) last_fall = n;
            end
        end else begin
            run = 0;
        end
        show_m = deb_m || ((n - last_fall) < SC);

        for (int c = 0; c < CH; c++) begin
            now_s = h_stat[i2][c];
            was_s = h_stat[i3][c];
            gap = n - 1 - last_edge[c];
            if (gap > FW) gap = FW;
            if (now_s != was_s) begin
                m_st[c]      = (gap < FW) ? M_FAULT : (now_s ? M_NOTCHG : M_CHG);
                last_edge[c] = n;
            end else if (m_st[c] == M_FAULT && gap == FW) begin
                m_st[c] = now_s ? M_NOTCHG : M_CHG;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        if (n + OFF >= HN) begin
            $display("FAIL history edge=%0d limit=%0d", n, HN - OFF);
            $fatal(1);
        end
        h_btn[n + OFF]  = button;
        h_usb[n + OFF]  = usb;
        h_lvl[n + OFF]  = level;
        h_stat[n + OFF] = stat;
        m_edge();
        #1;
        check_eq("red", 32'(red), 32'(m_red));
        check_eq("green", 32'(green), 32'(m_green));
        check_eq("fault", 32'(fault), 32'(m_fault));
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b1;
        #1;
        check_eq("rst_red", 32'(red), 0);
        check_eq("rst_green", 32'(green), 0);
        check_eq("rst_fault", 32'(fault), 0);
        repeat (cyc) @(posedge clk);
        #1;
        check_eq("rst_hold_red", 32'(red), 0);
        check_eq("rst_hold_green", 32'(green), 0);
        check_eq("rst_hold_fault", 32'(fault), 0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time=%0t limit=2000000", $time);
        $fatal(1);
    end

    initial begin
        int fast [CH];

        m_reset();
        do_reset(3);

        // Unplugged press: red from edge 11, held through the show tail
        button = 1'b1;
        repeat (10) tick();
        check_eq("press_e10_red0", 32'(red[0]), 0);
        tick();
        check_eq("press_e11_red0", 32'(red[0]), 1);
        repeat (9) tick();
        button = 1'b0;
        repeat (74) tick();
        check_eq("tail_e94_red0", 32'(red[0]), 1);
        tick();
        check_eq("tail_e95_red0", 32'(red[0]), 0);

        // Glitch rejection
        button = 1'b1;
        repeat (5) tick();
        button = 1'b0;
        repeat (25) tick();
        check_eq("glitch_red", 32'(red), 0);
        check_eq("glitch_green", 32'(green), 0);

        // Charging: stat 1 -> 0 on channel 0, visible three edges later
        usb  = 2'b11;
        stat = 2'b11;
        repeat (40) tick();
        stat[0] = 1'b0;
        tick();
        tick();
        tick();
        check_eq("chg_k2_red0", 32'(red[0]), 0);
        tick();
        check_eq("chg_k3_red0", 32'(red[0]), 1);
        check_eq("chg_k3_green0", 32'(green[0]), 1);
        check_eq("chg_k3_fault0", 32'(fault[0]), 0);

        // Fault on channel 1 while channel 0 shows level unplugged
        usb    = 2'b10;
        level  = 2'b01;
        button = 1'b1;
        repeat (15) tick();
        check_eq("indep_green0", 32'(green[0]), 1);
        for (int t = 0; t < 10; t++) begin
            stat[1] = ~stat[1];
            repeat (10) tick();
        end
        check_eq("flt_fault1", 32'(fault[1]), 1);
        check_eq("flt_green1", 32'(green[1]), 0);
        check_eq("flt_green0", 32'(green[0]), 1);
        repeat (50) tick();
        check_eq("exit_fault1", 32'(fault[1]), 0);
        check_eq("exit_green1", 32'(green[1]), 1);
        check_eq("exit_red1", 32'(red[1]), 0);

        // Reset during a fault blink
        for (int t = 0; t < 4; t++) begin
            stat[1] = ~stat[1];
            repeat (10) tick();
        end
        check_eq("pre_rst_fault1", 32'(fault[1]), 1);
        stat   = '0;
        button = 1'b0;
        do_reset(4);
        repeat (5) tick();
        stat[1] = 1'b1;
        repeat (8) tick();
        check_eq("post_rst_fault1", 32'(fault[1]), 0);

        // Random traffic with one reset in the middle
        for (int c = 0; c < CH; c++) fast[c] = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) begin
                for (int c = 0; c < CH; c++) fast[c] = int'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 24) == 0) button = ~button;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 63) == 0) usb[c]   = ~usb[c];
                if ($urandom_range(0, 63) == 0) level[c] = ~level[c];
                if (fast[c] == 1) begin
                    if ($urandom_range(0, 5) == 0) stat[c] = ~stat[c];
                end else begin
                    if ($urandom_range(0, 59) == 0) stat[c] = ~stat[c];
                end
            end
            if (i == 1000) do_reset(2);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
